// File: rtl/axi_rd_arb_pkg.sv
// Types and constants shared by the AXI read arbiter and its helpers.
package axi_rd_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ADDR = 1'b1
  } arb_state_e;

  // out_cnt width covers MAX_OUT up to 255
  localparam int OUT_CNT_W  = 8;
  localparam int PERF_CNT_W = 32;
  localparam int ID_W       = 4;

endpackage

// File: rtl/axi_defs.svh
// Shared AXI bus widths for the read-arbiter slice.
`ifndef AXI_DEFS_SVH
`define AXI_DEFS_SVH

`define AXI_ADDR_WTH 32
`define AXI_LEN_WTH  8
`define AXI_DATA_WTH 64
`define AXI_RESP_WTH 2

`endif

// File: rtl/axi_rd_arb_rr_pick.sv
// Round-robin picker: first requester after last_grant, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic               vld
);

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    // k walks the rotation order starting one past the previous winner
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!vld && req[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
          gnt[i] = 1'b1;
          vld    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_rd_arb.sv
// N:1 AXI read arbiter: round-robin AR grant with outstanding-burst limit, R routed by ID.
// Optional per-requester grant and AR stall counters when AXI_RD_ARB_PERF_CNT_EN is defined.
`include "axi_defs.svh"

module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    ce,
  input  logic [NUM_REQ-1:0][`AXI_ADDR_WTH-1:0]   req_araddr,
  input  logic [NUM_REQ-1:0][`AXI_LEN_WTH-1:0]    req_arlen,
  input  logic [NUM_REQ-1:0]                      req_arvalid,
  output logic [NUM_REQ-1:0]                      req_arready,
  output logic [`AXI_DATA_WTH-1:0]                req_rdata,
  output logic [`AXI_RESP_WTH-1:0]                req_rresp,
  output logic                                    req_rlast,
  output logic [NUM_REQ-1:0]                      req_rvalid,
  input  logic [NUM_REQ-1:0]                      req_rready,
  output logic [`AXI_ADDR_WTH-1:0]                araddr,
  output logic [`AXI_LEN_WTH-1:0]                 arlen,
  output logic                                    arvalid,
  output logic [ID_W-1:0]                         arid,
  input  logic                                    arready,
  input  logic [ID_W-1:0]                         rid_m,
  input  logic [`AXI_DATA_WTH-1:0]                rdata,
  input  logic [`AXI_RESP_WTH-1:0]                rresp,
  input  logic                                    rlast_d,
  input  logic                                    rvalid,
  output logic                                    rready,
`ifdef AXI_RD_ARB_PERF_CNT_EN
  output logic [NUM_REQ-1:0][PERF_CNT_W-1:0]      grant_cnt,
  output logic [PERF_CNT_W-1:0]                   stall_cnt,
`endif
  output logic                                    err_bad_id
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e           state;
  logic [IDX_W-1:0]     last_grant;
  logic [OUT_CNT_W-1:0] out_cnt;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic                 can_issue;
  logic                 ar_hs;
  logic                 r_done;
  logic                 id_ok;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req_arvalid),
    .last_grant (last_grant),
    .gnt        (pick_gnt),
    .vld        (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_idx = IDX_W'(i);
    end
  end

  assign can_issue = (out_cnt < OUT_CNT_W'(MAX_OUT));
  // arvalid is high exactly while in ADDR, so the handshake needs only state and arready
  assign ar_hs     = ce && (state == ADDR) && arready;
  assign r_done    = ce && rvalid && rready && rlast_d;

  always_comb begin
    req_arready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_arready[i] = ar_hs && (arid == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arlen      <= '0;
      arid       <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (pick_vld && can_issue) begin
            araddr  <= req_araddr[pick_idx];
            arlen   <= req_arlen[pick_idx];
            arid    <= ID_W'(pick_idx);
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid    <= 1'b0;
            last_grant <= arid[IDX_W-1:0];
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding bursts: +1 per AR accepted, -1 per last R beat consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (ar_hs && !r_done) begin
      out_cnt <= out_cnt + 1'b1;
    end else if (!ar_hs && r_done && (out_cnt != '0)) begin
      out_cnt <= out_cnt - 1'b1;
    end
  end

  // Unknown IDs are still drained so the slave never stalls on them
  always_comb begin
    req_rvalid = '0;
    rready     = 1'b1;
    id_ok      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rid_m == ID_W'(i)) begin
        id_ok         = 1'b1;
        req_rvalid[i] = rvalid;
        rready        = req_rready[i];
      end
    end
  end

  assign req_rdata = rdata;
  assign req_rresp = rresp;
  assign req_rlast = rlast_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_bad_id <= 1'b0;
    end else if (ce && rvalid && !id_ok) begin
      err_bad_id <= 1'b1;
    end
  end

`ifdef AXI_RD_ARB_PERF_CNT_EN
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else if (ce) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_arready[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
      end
      if ((state == ADDR) && !arready) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_arb.sv
// Self-checking bench for axi_rd_arb (NUM_REQ=4, MAX_OUT=4): directed scenarios plus randomized traffic.
module tb_axi_rd_arb;

  localparam int N  = 4;
  localparam int MO = 4;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int DW = 64;

  logic                 clk = 1'b0;
  logic                 rst, ce;
  logic [N-1:0][AW-1:0] req_araddr;
  logic [N-1:0][LW-1:0] req_arlen;
  logic [N-1:0]         req_arvalid, req_arready, req_rvalid, req_rready;
  logic [DW-1:0]        req_rdata, rdata;
  logic [1:0]           req_rresp, rresp;
  logic                 req_rlast;
  logic [AW-1:0]        araddr;
  logic [LW-1:0]        arlen;
  logic                 arvalid, arready, rlast_d, rvalid, rready, err_bad_id;
  logic [3:0]           arid, rid_m;
`ifdef AXI_RD_ARB_PERF_CNT_EN
  logic [N-1:0][31:0]   grant_cnt;
  logic [31:0]          stall_cnt;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_rd_arb #(.NUM_REQ(N), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
    .req_rvalid(req_rvalid), .req_rready(req_rready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arid(arid), .arready(arready),
    .rid_m(rid_m), .rdata(rdata), .rresp(rresp), .rlast_d(rlast_d), .rvalid(rvalid),
    .rready(rready),
`ifdef AXI_RD_ARB_PERF_CNT_EN
    .grant_cnt(grant_cnt), .stall_cnt(stall_cnt),
`endif
    .err_bad_id(err_bad_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b1; req_arvalid = '0; arready = 1'b0;
    rvalid = 1'b0; rlast_d = 1'b0; rid_m = '0; req_rready = '0;
    rdata = '0; rresp = '0;
    step(); step();
    rst = 1'b0;
  endtask

  // Single-beat last R response for requester id
  task automatic r_beat(input int id);
    rvalid = 1'b1; rid_m = 4'(id); rlast_d = 1'b1; req_rready = '1;
    step();
    rvalid = 1'b0; rlast_d = 1'b0;
  endtask

  task automatic issue_one(input int idx);
    int n = 0;
    req_arvalid[idx] = 1'b1; req_araddr[idx] = $urandom; req_arlen[idx] = 8'($urandom);
    arready = 1'b1;
    @(negedge clk);
    while (!req_arready[idx] && n < 10) begin step(); @(negedge clk); n++; end
    checks++;
    if (n >= 10) begin errs++; $display("FAIL issue_timeout req=%0d got no req_arready in %0d cycles", idx, n); end
    step();
    req_arvalid[idx] = 1'b0;
  endtask

  // Reference round-robin: first asserted requester after last, wrapping
  function automatic int rr_next(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin errs++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
    checks++; if (araddr !== '0) begin errs++; $display("FAIL rst_araddr got=%h exp=0", araddr); end
    checks++; if (arlen !== '0 || arid !== '0) begin errs++; $display("FAIL rst_arlen_arid got=%h/%h exp=0/0", arlen, arid); end
    checks++; if (req_arready !== '0) begin errs++; $display("FAIL rst_req_arready got=%b exp=0000", req_arready); end
    checks++; if (err_bad_id !== 1'b0) begin errs++; $display("FAIL rst_err got=%b exp=0", err_bad_id); end
    step();
  endtask

  task automatic test_rr_order();
    logic [AW-1:0] a [N];
    int n;
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom; req_araddr[i] = a[i]; req_arlen[i] = 8'(i + 3);
    end
    arready = 1'b1; req_arvalid = '1;
    for (int g = 0; g < 5; g++) begin
      int eg;
      eg = g % N;
      n = 0;
      @(negedge clk);
      while (!arvalid && n < 8) begin step(); @(negedge clk); n++; end
      checks++; if (n != ((g == 0) ? 1 : 0)) begin errs++; $display("FAIL rr_latency g=%0d got=%0d exp=%0d", g, n, (g == 0) ? 1 : 0); end
      checks++; if (arid !== 4'(eg)) begin errs++; $display("FAIL rr_arid g=%0d got=%0d exp=%0d", g, arid, eg); end
      checks++; if (araddr !== a[eg] || arlen !== 8'(eg + 3)) begin errs++; $display("FAIL rr_addr g=%0d got=%h/%0d exp=%h/%0d", g, araddr, arlen, a[eg], eg + 3); end
      checks++; if (req_arready !== 4'(1 << eg)) begin errs++; $display("FAIL rr_arready g=%0d got=%b exp=%b", g, req_arready, 4'(1 << eg)); end
      step();
      if (g == 4) req_arvalid = '0;
      rvalid = 1'b1; rid_m = 4'(eg); rlast_d = 1'b1; req_rready = '1;
      @(negedge clk);
      checks++; if (arvalid !== 1'b0) begin errs++; $display("FAIL rr_drop g=%0d arvalid got=%b exp=0", g, arvalid); end
      step();
      rvalid = 1'b0; rlast_d = 1'b0;
    end
  endtask

  task automatic test_ar_stall();
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    int pulses = 0;
    a = $urandom; l = 8'($urandom);
    req_araddr[2] = a; req_arlen[2] = l; req_arvalid = 4'b0100; arready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 5) arready = 1'b1;
      @(negedge clk);
      checks++; if (arvalid !== 1'b1 || araddr !== a || arlen !== l || arid !== 4'd2) begin
        errs++; $display("FAIL stall_stable c=%0d got v=%b a=%h l=%0d id=%0d exp v=1 a=%h l=%0d id=2", c, arvalid, araddr, arlen, arid, a, l);
      end
      if (req_arready !== '0) pulses++;
      checks++; if (req_arready !== ((c == 5) ? 4'b0100 : 4'b0000)) begin errs++; $display("FAIL stall_arready c=%0d got=%b exp=%b", c, req_arready, (c == 5) ? 4'b0100 : 4'b0000); end
    end
    checks++; if (pulses != 1) begin errs++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
    step();
    req_arvalid = '0; arready = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0 || req_arready !== '0) begin errs++; $display("FAIL stall_after got v=%b rdy=%b exp 0/0000", arvalid, req_arready); end
`ifdef AXI_RD_ARB_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd5) begin errs++; $display("FAIL perf_stall got=%0d exp=5", stall_cnt); end
`endif
    r_beat(2);
  endtask

  task automatic test_ce();
    logic [AW-1:0] a;
    a = $urandom;
    req_araddr[0] = a; req_arvalid = 4'b0001; arready = 1'b0;
    step();
    ce = 1'b0; arready = 1'b1;
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || req_arready !== '0) begin errs++; $display("FAIL ce_hold1 got v=%b rdy=%b exp 1/0000", arvalid, req_arready); end
    step();
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== a) begin errs++; $display("FAIL ce_hold2 got v=%b id=%0d a=%h exp 1/0/%h", arvalid, arid, araddr, a); end
    step();
    ce = 1'b1;
    @(negedge clk);
    checks++; if (req_arready !== 4'b0001) begin errs++; $display("FAIL ce_resume got=%b exp=0001", req_arready); end
    step();
    req_arvalid = '0; arready = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin errs++; $display("FAIL ce_drop got=%b exp=0", arvalid); end
    r_beat(0);
  endtask

  task automatic test_max_out();
    issue_one(1); issue_one(2); issue_one(3); issue_one(0);
    req_arvalid[1] = 1'b1; req_araddr[1] = $urandom; arready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (arvalid !== 1'b0) begin errs++; $display("FAIL max_block c=%0d got=%b exp=0", c, arvalid); end
      step();
    end
    rvalid = 1'b1; rid_m = 4'd2; rlast_d = 1'b1; req_rready = 4'b0100;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin errs++; $display("FAIL max_beat_cycle got=%b exp=0", arvalid); end
    step();
    rvalid = 1'b0; rlast_d = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== 4'd1) begin errs++; $display("FAIL max_regrant got v=%b id=%0d exp 1/1", arvalid, arid); end
    step();
    req_arvalid[1] = 1'b0;
  endtask

  task automatic test_r_route();
    int b = 0;
    int n = 0;
    while (b < 4 && n < 40) begin
      rvalid = 1'b1; rid_m = 4'd1; rlast_d = (b == 3); rdata = {$urandom, $urandom}; rresp = 2'($urandom);
      req_rready = 4'($urandom); req_rready[1] = n[0];
      @(negedge clk);
      checks++; if (req_rvalid !== 4'b0010) begin errs++; $display("FAIL route_rvalid n=%0d got=%b exp=0010", n, req_rvalid); end
      checks++; if (rready !== req_rready[1]) begin errs++; $display("FAIL route_rready n=%0d got=%b exp=%b", n, rready, req_rready[1]); end
      checks++; if (req_rdata !== rdata || req_rresp !== rresp || req_rlast !== rlast_d) begin errs++; $display("FAIL route_data n=%0d got=%h/%0d/%b exp=%h/%0d/%b", n, req_rdata, req_rresp, req_rlast, rdata, rresp, rlast_d); end
      if (req_rready[1]) b++;
      step();
      n++;
    end
    rvalid = 1'b0; rlast_d = 1'b0;
    checks++; if (b != 4) begin errs++; $display("FAIL route_timeout beats got=%0d exp=4", b); end
    req_araddr[0] = $urandom; req_araddr[3] = $urandom; req_arvalid = 4'b1001; arready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== 4'd3) begin errs++; $display("FAIL route_one_slot got v=%b id=%0d exp 1/3", arvalid, arid); end
    step();
    req_arvalid[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (arvalid !== 1'b0) begin errs++; $display("FAIL route_full c=%0d got=%b exp=0", c, arvalid); end
      step();
    end
  endtask

  task automatic test_bad_id();
    rvalid = 1'b1; rid_m = 4'd9; rlast_d = 1'b1; req_rready = '0;
    @(negedge clk);
    checks++; if (rready !== 1'b1 || req_rvalid !== '0) begin errs++; $display("FAIL bad_route got rready=%b rvalid=%b exp 1/0000", rready, req_rvalid); end
    step();
    rvalid = 1'b0; rlast_d = 1'b0;
    @(negedge clk);
    checks++; if (err_bad_id !== 1'b1) begin errs++; $display("FAIL bad_err_set got=%b exp=1", err_bad_id); end
    step();
    @(negedge clk);
    checks++; if (arvalid !== 1'b1 || arid !== 4'd0) begin errs++; $display("FAIL bad_decrement got v=%b id=%0d exp 1/0", arvalid, arid); end
    step();
    req_arvalid = '0;
    step(); step(); step();
    @(negedge clk);
    checks++; if (err_bad_id !== 1'b1) begin errs++; $display("FAIL bad_err_sticky got=%b exp=1", err_bad_id); end
    step();
  endtask

  task automatic test_reset_midburst();
    r_beat(0);
    req_arvalid = 4'b0100; req_araddr[2] = $urandom; arready = 1'b0;
    step();
    @(negedge clk);
    checks++; if (arvalid !== 1'b1) begin errs++; $display("FAIL mid_in_addr got=%b exp=1", arvalid); end
    rst = 1'b1; req_arvalid = '0; arready = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0 || araddr !== '0 || arid !== '0 || req_arready !== '0) begin errs++; $display("FAIL mid_rst got v=%b a=%h id=%0d rdy=%b exp 0/0/0/0000", arvalid, araddr, arid, req_arready); end
    checks++; if (err_bad_id !== 1'b0) begin errs++; $display("FAIL mid_err_clr got=%b exp=0", err_bad_id); end
`ifdef AXI_RD_ARB_PERF_CNT_EN
    checks++; if (grant_cnt !== '0 || stall_cnt !== '0) begin errs++; $display("FAIL mid_perf got g=%h s=%0d exp 0/0", grant_cnt, stall_cnt); end
`endif
    step();
    issue_one(0); issue_one(1); issue_one(2); issue_one(3);
    req_arvalid[0] = 1'b1; arready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (arvalid !== 1'b0) begin errs++; $display("FAIL mid_out_cleared c=%0d got=%b exp=0", c, arvalid); end
      step();
    end
    req_arvalid = '0;
  endtask

  task automatic test_random();
    int last_m = N - 1;
    int out_m  = 0;
    int p_out  = 0;
    int cur_g  = 0;
    int q[$];
    logic [N-1:0]         p_req = '0;
    logic [N-1:0]         hs_vec = '0;
    logic [N-1:0]         exp_ra, exp_rv;
    logic [N-1:0][AW-1:0] p_addr = '0;
    logic                 p_av = 1'b0;
    logic                 p_hs = 1'b0;
    logic                 exp_av, hs, rd, exp_rr;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_arvalid[i] && hs_vec[i]) req_arvalid[i] = 1'b0;
        else if (!req_arvalid[i] && $urandom_range(0, 3) == 0) begin
          req_arvalid[i] = 1'b1; req_araddr[i] = $urandom; req_arlen[i] = 8'($urandom);
        end
      end
      arready = ($urandom_range(0, 2) != 0);
      req_rready = 4'($urandom);
      rdata = {$urandom, $urandom}; rresp = 2'($urandom);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rvalid = 1'b1; rid_m = 4'(q[0]); rlast_d = 1'b1;
      end else begin
        rvalid = 1'b0; rlast_d = 1'b0; rid_m = 4'($urandom);
      end
      @(negedge clk);
      if (p_av) exp_av = !p_hs;
      else      exp_av = (p_req != '0) && (p_out < MO);
      checks++; if (arvalid !== exp_av) begin errs++; $display("FAIL rnd_arvalid c=%0d got=%b exp=%b", c, arvalid, exp_av); end
      if (exp_av && !p_av) cur_g = rr_next(p_req, last_m);
      if (exp_av) begin
        checks++; if (arid !== 4'(cur_g) || araddr !== p_addr[cur_g]) begin errs++; $display("FAIL rnd_grant c=%0d got id=%0d a=%h exp id=%0d a=%h", c, arid, araddr, cur_g, p_addr[cur_g]); end
      end
      hs = exp_av && arready;
      exp_ra = hs ? 4'(1 << cur_g) : 4'b0000;
      checks++; if (req_arready !== exp_ra) begin errs++; $display("FAIL rnd_arready c=%0d got=%b exp=%b", c, req_arready, exp_ra); end
      exp_rr = (rid_m < N) ? req_rready[rid_m] : 1'b1;
      exp_rv = '0;
      if (rvalid && rid_m < N) exp_rv[rid_m] = 1'b1;
      checks++; if (rready !== exp_rr || req_rvalid !== exp_rv) begin errs++; $display("FAIL rnd_r c=%0d got rr=%b rv=%b exp rr=%b rv=%b", c, rready, req_rvalid, exp_rr, exp_rv); end
      rd = rvalid && exp_rr && rlast_d;
      hs_vec = exp_ra;
      if (hs) begin q.push_back(cur_g); last_m = cur_g; end
      if (rd) void'(q.pop_front());
      p_out = out_m;
      out_m = out_m + int'(hs) - int'(rd);
      p_req = req_arvalid; p_av = exp_av; p_hs = hs; p_addr = req_araddr;
      step();
    end
    req_arvalid = '0; rvalid = 1'b0; rlast_d = 1'b0; arready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_araddr = '0; req_arlen = '0;
    test_reset();
    test_rr_order();
    test_ar_stall();
    test_ce();
    test_max_out();
    test_r_route();
    test_bad_id();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
